// File: rtl/fetch_sequencer_if.sv
// Handshake and status bundle between the fetch sequencer and its surroundings.
// The sequencer side uses the master modport and the environment the slave one.
// FETCH_SEQ_PERF_EN adds the stall_cycles performance counter to the bundle.
interface fetch_sequencer_if #(
  parameter int STEP_W = 16,
  parameter int IDX_W  = 8
);
  logic              start;
  logic [STEP_W-1:0] num_steps;
  logic              mac_ready;
  logic              wb_done;
  logic              init_start;
  logic              enable;
  logic              finished_one_row;
  logic              final_done;
  logic [IDX_W-1:0]  row_idx;
  logic [IDX_W-1:0]  col_idx;
  logic [STEP_W-1:0] step_idx;
  logic              busy;
  logic              done;
`ifdef FETCH_SEQ_PERF_EN
  logic [31:0]       stall_cycles;
`endif

  modport master (
    input  start, num_steps, mac_ready, wb_done,
    output init_start, enable, finished_one_row, final_done,
    output row_idx, col_idx, step_idx, busy, done
`ifdef FETCH_SEQ_PERF_EN
    , output stall_cycles
`endif
  );

  modport slave (
    output start, num_steps, mac_ready, wb_done,
    input  init_start, enable, finished_one_row, final_done,
    input  row_idx, col_idx, step_idx, busy, done
`ifdef FETCH_SEQ_PERF_EN
    , input stall_cycles
`endif
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Operand fetch controller for the Euler accelerator.
// Per Euler step it walks an N x N matrix row by row, strobing the fetch stage
// to advance, rewind the vector PC at each row end and rewind both PCs at the
// end of the matrix, then waits for the state writeback before the next step.
// Optional: define FETCH_SEQ_PERF_EN to add a saturating stall_cycles counter.
module fetch_sequencer #(
  parameter int N      = 5,
  parameter int STEP_W = 16,
  parameter int IDX_W  = 8
) (
  input logic                clk,
  input logic                reset,
  fetch_sequencer_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    FETCH,
    WB,
    DONE
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  state_t            state;
  logic [IDX_W-1:0]  row_q;
  logic [IDX_W-1:0]  col_q;
  logic [STEP_W-1:0] step_q;
  logic [STEP_W-1:0] steps_q;
  logic              init_q;
  logic              busy_q;
  logic              done_q;

  logic              fetch_en;
  logic              row_end;
  logic              mat_end;

  // Fetch strobes follow mac_ready in the same cycle so no operand slot is lost.
  always_comb begin
    fetch_en = (state == FETCH) && bus.mac_ready;
    row_end  = fetch_en && (col_q == LAST_IDX);
    mat_end  = row_end && (row_q == LAST_IDX);
  end

  // Sequencer state, indices and registered pulse/status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      step_q  <= '0;
      steps_q <= '0;
      init_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      init_q <= 1'b0;
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            busy_q <= 1'b1;
            if (bus.num_steps != '0) begin
              steps_q <= bus.num_steps;
              init_q  <= 1'b1;
              state   <= INIT;
            end else begin
              done_q <= 1'b1;
              state  <= DONE;
            end
          end
        end
        INIT: begin
          row_q  <= '0;
          col_q  <= '0;
          step_q <= '0;
          state  <= FETCH;
        end
        FETCH: begin
          if (fetch_en) begin
            if (row_end) begin
              col_q <= '0;
              if (mat_end) begin
                row_q <= '0;
                state <= WB;
              end else begin
                row_q <= row_q + IDX_W'(1);
              end
            end else begin
              col_q <= col_q + IDX_W'(1);
            end
          end
        end
        WB: begin
          if (bus.wb_done) begin
            if (step_q == steps_q - STEP_W'(1)) begin
              done_q <= 1'b1;
              state  <= DONE;
            end else begin
              step_q <= step_q + STEP_W'(1);
              state  <= FETCH;
            end
          end
        end
        DONE: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.init_start       = init_q;
  assign bus.enable           = fetch_en;
  assign bus.finished_one_row = row_end;
  assign bus.final_done       = mat_end;
  assign bus.row_idx          = row_q;
  assign bus.col_idx          = col_q;
  assign bus.step_idx         = step_q;
  assign bus.busy             = busy_q;
  assign bus.done             = done_q;

`ifdef FETCH_SEQ_PERF_EN
  logic [31:0] stall_q;

  // Count FETCH cycles lost to MAC back-pressure, saturating at all-ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
    end else if (state == INIT) begin
      stall_q <= '0;
    end else if ((state == FETCH) && !bus.mac_ready && (stall_q != '1)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign bus.stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer. Expected values come from a
// run-level model: fetch k of a step maps to row k/N, col k%N, and strobe/count
// totals follow from num_steps, N and the stall/writeback delays chosen here.
module tb_fetch_sequencer;
  localparam int N      = 5;
  localparam int STEP_W = 16;
  localparam int IDX_W  = 8;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  int total_checks  = 0;
  int passed_checks = 0;
  int ev_init, ev_en, ev_row, ev_final, ev_done, run_cycles;

  fetch_sequencer_if #(.STEP_W(STEP_W), .IDX_W(IDX_W)) bus ();

  fetch_sequencer #(.N(N), .STEP_W(STEP_W), .IDX_W(IDX_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  // Hard stop in case something stalls the directed sequence.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    total_checks++;
    assert (observed === expected) passed_checks++;
    else $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
  endtask

  task automatic sample_events();
    ev_init    += int'(bus.init_start);
    ev_en      += int'(bus.enable);
    ev_row     += int'(bus.finished_one_row);
    ev_final   += int'(bus.final_done);
    ev_done    += int'(bus.done);
    run_cycles += 1;
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_init"},  32'(bus.init_start), 0);
    check_output({tag, "_en"},    32'(bus.enable), 0);
    check_output({tag, "_row_s"}, 32'(bus.finished_one_row), 0);
    check_output({tag, "_final"}, 32'(bus.final_done), 0);
    check_output({tag, "_done"},  32'(bus.done), 0);
    check_output({tag, "_busy"},  32'(bus.busy), 0);
    check_output({tag, "_row"},   32'(bus.row_idx), 0);
    check_output({tag, "_col"},   32'(bus.col_idx), 0);
    check_output({tag, "_step"},  32'(bus.step_idx), 0);
`ifdef FETCH_SEQ_PERF_EN
    check_output({tag, "_stall"}, bus.stall_cycles, 0);
`endif
  endtask

  // ready_mode: 0 always ready, 1 alternating 1/0, 2 random.
  // wb_fixed < 0 picks a random writeback delay per step.
  task automatic apply_stimulus(input int steps, input int ready_mode,
                                input bit disturb, input int wb_fixed);
    int  k, stalls, streak, fcyc, wb_wait, wb_total;
    bit  rdy;
    ev_init = 0; ev_en = 0; ev_row = 0; ev_final = 0; ev_done = 0;
    run_cycles = 0; stalls = 0; wb_total = 0;

    bus.start     = 1'b1;
    bus.num_steps = STEP_W'(steps);
    bus.mac_ready = 1'($urandom_range(0, 1));
    bus.wb_done   = 1'b0;
    #1;
    check_output("idle_busy", 32'(bus.busy), 0);
    tick();
    bus.start     = 1'b0;
    bus.num_steps = STEP_W'($urandom);
    #1;
    sample_events();

    if (steps == 0) begin
      check_output("zero_done", 32'(bus.done), 1);
      check_output("zero_init", 32'(bus.init_start), 0);
      check_output("zero_en",   32'(bus.enable), 0);
      tick();
      #1;
      check_output("zero_done_after", 32'(bus.done), 0);
      check_output("zero_busy_after", 32'(bus.busy), 0);
      check_output("zero_en_after",   32'(bus.enable), 0);
      return;
    end

    check_output("init_pulse", 32'(bus.init_start), 1);
    check_output("init_en",    32'(bus.enable), 0);
    check_output("init_busy",  32'(bus.busy), 1);

    for (int s = 0; s < steps; s++) begin
      k = 0; streak = 0; fcyc = 0;
      while (k < N * N) begin
        tick();
        case (ready_mode)
          0:       rdy = 1'b1;
          1:       rdy = (fcyc % 2 == 0);
          default: rdy = (streak >= 4) ? 1'b1 : 1'($urandom_range(0, 1));
        endcase
        bus.mac_ready = rdy;
        bus.start     = disturb && (fcyc == 3);
        bus.wb_done   = disturb && (fcyc == 9);
        bus.num_steps = STEP_W'($urandom);
        #1;
        sample_events();
        check_output("f_en",    32'(bus.enable), 32'(rdy));
        check_output("f_row_s", 32'(bus.finished_one_row),
                     (rdy && (k % N == N - 1)) ? 1 : 0);
        check_output("f_final", 32'(bus.final_done),
                     (rdy && (k == N * N - 1)) ? 1 : 0);
        check_output("f_row",   32'(bus.row_idx), 32'(k / N));
        check_output("f_col",   32'(bus.col_idx), 32'(k % N));
        check_output("f_step",  32'(bus.step_idx), 32'(s));
        check_output("f_busy",  32'(bus.busy), 1);
        if (rdy) begin
          k++;
          streak = 0;
        end else begin
          stalls++;
          streak++;
        end
        fcyc++;
      end

      wb_wait = (wb_fixed < 0) ? int'($urandom_range(0, 4)) : wb_fixed;
      wb_total += wb_wait + 1;
      for (int i = 0; i <= wb_wait; i++) begin
        tick();
        bus.start     = disturb && (i == 0);
        bus.mac_ready = 1'($urandom_range(0, 1));
        bus.wb_done   = (i == wb_wait);
        #1;
        sample_events();
        check_output("wb_en",    32'(bus.enable), 0);
        check_output("wb_row_s", 32'(bus.finished_one_row), 0);
        check_output("wb_final", 32'(bus.final_done), 0);
        check_output("wb_step",  32'(bus.step_idx), 32'(s));
        check_output("wb_col",   32'(bus.col_idx), 0);
        check_output("wb_busy",  32'(bus.busy), 1);
        check_output("wb_done_o", 32'(bus.done), 0);
      end
    end

    tick();
    bus.wb_done = 1'b0;
    bus.start   = 1'b0;
    #1;
    sample_events();
    check_output("d_done", 32'(bus.done), 1);
    check_output("d_busy", 32'(bus.busy), 1);
    check_output("d_step", 32'(bus.step_idx), 32'(steps - 1));
    check_output("d_en",   32'(bus.enable), 0);
`ifdef FETCH_SEQ_PERF_EN
    check_output("d_stall", bus.stall_cycles, 32'(stalls));
`endif
    tick();
    #1;
    check_output("post_done", 32'(bus.done), 0);
    check_output("post_busy", 32'(bus.busy), 0);

    check_output("cnt_init",  32'(ev_init), 1);
    check_output("cnt_en",    32'(ev_en), 32'(steps * N * N));
    check_output("cnt_row",   32'(ev_row), 32'(steps * N));
    check_output("cnt_final", 32'(ev_final), 32'(steps));
    check_output("cnt_done",  32'(ev_done), 1);
    check_output("cnt_len",   32'(run_cycles),
                 32'(2 + steps * N * N + stalls + wb_total));
  endtask

  // Directed sequence of scenarios.
  initial begin
    bus.start     = 1'b0;
    bus.num_steps = '0;
    bus.mac_ready = 1'b0;
    bus.wb_done   = 1'b0;
    #2;
    check_all_zero("rst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    $display("[TB] single step, always ready");
    apply_stimulus(1, 0, 1'b0, 3);
    $display("[TB] three steps, always ready");
    apply_stimulus(3, 0, 1'b0, 3);
    $display("[TB] alternating mac_ready");
    apply_stimulus(1, 1, 1'b0, 2);
    $display("[TB] zero steps");
    apply_stimulus(0, 0, 1'b0, 0);

    $display("[TB] reset in the 12th fetch cycle");
    bus.start     = 1'b1;
    bus.num_steps = STEP_W'(2);
    bus.mac_ready = 1'b1;
    tick();
    bus.start = 1'b0;
    #1;
    check_output("rr_init", 32'(bus.init_start), 1);
    for (int c = 0; c < 11; c++) begin
      tick();
      #1;
      check_output("rr_col", 32'(bus.col_idx), 32'(c % N));
    end
    tick();
    #1;
    reset = 1'b0;
    #1;
    check_all_zero("rr");
    @(negedge clk);
    reset = 1'b1;
    apply_stimulus(1, 0, 1'b0, 3);

    $display("[TB] disturbed run");
    apply_stimulus(2, 0, 1'b1, 1);
    $display("[TB] random runs");
    apply_stimulus(2, 2, 1'b0, -1);
    apply_stimulus(int'($urandom_range(1, 3)), 2, 1'b1, -1);

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
